// File: rtl/cpu_pkg.sv
// Shared widths and writeback-grant encodings for the register-file write path.
package cpu_pkg;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 3;
    localparam int NREGS  = 2 ** ADDR_W;

    localparam logic GRANT_ALU = 1'b0;
    localparam logic GRANT_MEM = 1'b1;

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin arbiter (req[0]=ALU, req[1]=MEM), one-hot grant, combinational.
// last_grant advances only on a transfer, so a stalled winner keeps its claim.
module rr_arb2
    import cpu_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req_i,
    input  logic       upd_i,
    output logic [1:0] gnt_o
);

    logic last_grant_q;
    logic last_grant_d;

    always_comb begin
        gnt_o = 2'b00;
        case (req_i)
            2'b01:   gnt_o = 2'b01;
            2'b10:   gnt_o = 2'b10;
            2'b11:   gnt_o = (last_grant_q == GRANT_MEM) ? 2'b01 : 2'b10;
            default: gnt_o = 2'b00;
        endcase
    end

    always_comb begin
        last_grant_d = last_grant_q;
        if (upd_i) begin
            last_grant_d = gnt_o[1] ? GRANT_MEM : GRANT_ALU;
        end
    end

    // Reset to MEM so the ALU wins the first tie.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant_q <= GRANT_MEM;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end

endmodule

// File: rtl/rf_writeback_ctrl.sv
// Arbitrates ALU and load-return writebacks onto the single reg_file write port.
// Tracks the one outstanding load destination and flags read hazards for the decode stage.
module rf_writeback_ctrl #(
    parameter int DATA_W = cpu_pkg::DATA_W,
    parameter int ADDR_W = cpu_pkg::ADDR_W,
    parameter int NREGS  = cpu_pkg::NREGS
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              alu_valid,
    input  logic [ADDR_W-1:0] alu_addr,
    input  logic [DATA_W-1:0] alu_data,
    output logic              alu_ready,
    input  logic              ld_issue,
    input  logic [ADDR_W-1:0] ld_issue_addr,
    input  logic              mem_valid,
    input  logic [DATA_W-1:0] mem_data,
    output logic              mem_ready,
    output logic              ld_busy,
    input  logic [ADDR_W-1:0] rd1_addr,
    input  logic [ADDR_W-1:0] rd2_addr,
    output logic              hazard1,
    output logic              hazard2,
    output logic              rf_write,
    output logic [ADDR_W-1:0] rf_inaddress,
    output logic [DATA_W-1:0] rf_in
);

    if (NREGS != (1 << ADDR_W)) begin : g_bad_nregs
        $error("NREGS must equal 2**ADDR_W");
    end

    logic              ld_busy_q, ld_busy_d;
    logic [ADDR_W-1:0] ld_addr_q, ld_addr_d;
    logic              rf_write_q, rf_write_d;
    logic [ADDR_W-1:0] rf_inaddress_q, rf_inaddress_d;
    logic [DATA_W-1:0] rf_in_q, rf_in_d;

    logic       alu_elig;
    logic       mem_elig;
    logic [1:0] gnt;

    // An ALU write to the pending load's destination must wait so the load cannot overwrite it later.
    assign alu_elig = alu_valid && !(ld_busy_q && (alu_addr == ld_addr_q));
    assign mem_elig = mem_valid && ld_busy_q;

    rr_arb2 u_arb (
        .clk   (CLK),
        .rst_n (RESET),
        .req_i ({mem_elig, alu_elig}),
        .upd_i (|gnt),
        .gnt_o (gnt)
    );

    assign alu_ready = gnt[0];
    assign mem_ready = gnt[1];

    always_comb begin
        ld_busy_d      = ld_busy_q;
        ld_addr_d      = ld_addr_q;
        rf_write_d     = 1'b0;
        rf_inaddress_d = rf_inaddress_q;
        rf_in_d        = rf_in_q;

        if (mem_ready) begin
            ld_busy_d = 1'b0;
        end
        // A new issue is accepted when idle or when the current load retires this same edge.
        if (ld_issue && (!ld_busy_q || mem_ready)) begin
            ld_busy_d = 1'b1;
            ld_addr_d = ld_issue_addr;
        end

        if (alu_ready) begin
            rf_write_d     = 1'b1;
            rf_inaddress_d = alu_addr;
            rf_in_d        = alu_data;
        end else if (mem_ready) begin
            rf_write_d     = 1'b1;
            rf_inaddress_d = ld_addr_q;
            rf_in_d        = mem_data;
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            ld_busy_q      <= 1'b0;
            ld_addr_q      <= '0;
            rf_write_q     <= 1'b0;
            rf_inaddress_q <= '0;
            rf_in_q        <= '0;
        end else begin
            ld_busy_q      <= ld_busy_d;
            ld_addr_q      <= ld_addr_d;
            rf_write_q     <= rf_write_d;
            rf_inaddress_q <= rf_inaddress_d;
            rf_in_q        <= rf_in_d;
        end
    end

    assign ld_busy      = ld_busy_q;
    assign rf_write     = rf_write_q;
    assign rf_inaddress = rf_inaddress_q;
    assign rf_in        = rf_in_q;

    assign hazard1 = (ld_busy_q && (rd1_addr == ld_addr_q)) || (rf_write_q && (rd1_addr == rf_inaddress_q));
    assign hazard2 = (ld_busy_q && (rd2_addr == ld_addr_q)) || (rf_write_q && (rd2_addr == rf_inaddress_q));

endmodule

// File: tb/tb_rf_writeback_ctrl.sv
// Directed bench for rf_writeback_ctrl: arbitration, load tracking, WAW blocking, hazards, async reset.
module tb_rf_writeback_ctrl;

    localparam int DW = 8;
    localparam int AW = 3;

    logic          CLK;
    logic          RESET;
    logic          alu_valid;
    logic [AW-1:0] alu_addr;
    logic [DW-1:0] alu_data;
    logic          alu_ready;
    logic          ld_issue;
    logic [AW-1:0] ld_issue_addr;
    logic          mem_valid;
    logic [DW-1:0] mem_data;
    logic          mem_ready;
    logic          ld_busy;
    logic [AW-1:0] rd1_addr;
    logic [AW-1:0] rd2_addr;
    logic          hazard1;
    logic          hazard2;
    logic          rf_write;
    logic [AW-1:0] rf_inaddress;
    logic [DW-1:0] rf_in;

    int n_tests = 0;
    int n_fail  = 0;

    rf_writeback_ctrl #(.DATA_W(DW), .ADDR_W(AW), .NREGS(8)) dut (
        .CLK           (CLK),
        .RESET         (RESET),
        .alu_valid     (alu_valid),
        .alu_addr      (alu_addr),
        .alu_data      (alu_data),
        .alu_ready     (alu_ready),
        .ld_issue      (ld_issue),
        .ld_issue_addr (ld_issue_addr),
        .mem_valid     (mem_valid),
        .mem_data      (mem_data),
        .mem_ready     (mem_ready),
        .ld_busy       (ld_busy),
        .rd1_addr      (rd1_addr),
        .rd2_addr      (rd2_addr),
        .hazard1       (hazard1),
        .hazard2       (hazard2),
        .rf_write      (rf_write),
        .rf_inaddress  (rf_inaddress),
        .rf_in         (rf_in)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Advance to just after the next rising edge; inputs are driven from here.
    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk_wr(input string tag, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
        chk({tag, ".wr"},   32'(rf_write),     32'(w));
        chk({tag, ".addr"}, 32'(rf_inaddress), 32'(a));
        chk({tag, ".data"}, 32'(rf_in),        32'(d));
    endtask

    task automatic idle();
        alu_valid = 0; alu_addr = 0; alu_data = 0;
        ld_issue = 0; ld_issue_addr = 0;
        mem_valid = 0; mem_data = 0;
    endtask

    initial begin
        idle();
        rd1_addr = 0; rd2_addr = 0;
        RESET = 0;
        #12;
        chk_wr("reset", 0, 0, 0);
        chk("reset.busy", 32'(ld_busy), 0);
        chk("reset.hz1", 32'(hazard1), 0);
        chk("reset.hz2", 32'(hazard2), 0);
        #4 RESET = 1;

        // Contention: load on 2 pending, first tie goes to the ALU, then MEM, then the waiting ALU.
        step();
        ld_issue = 1; ld_issue_addr = 2;
        step();
        ld_issue = 0;
        chk("cont.busy", 32'(ld_busy), 1);
        alu_valid = 1; alu_addr = 1; alu_data = 8'h11;
        mem_valid = 1; mem_data = 8'h22;
        #1;
        chk("cont.alu_rdy0", 32'(alu_ready), 1);
        chk("cont.mem_rdy0", 32'(mem_ready), 0);
        step();
        chk_wr("cont.w1", 1, 1, 8'h11);
        alu_addr = 7; alu_data = 8'h33;
        #1;
        chk("cont.alu_rdy1", 32'(alu_ready), 0);
        chk("cont.mem_rdy1", 32'(mem_ready), 1);
        step();
        chk_wr("cont.w2", 1, 2, 8'h22);
        chk("cont.busy_clr", 32'(ld_busy), 0);
        mem_valid = 0;
        #1;
        chk("cont.alu_rdy2", 32'(alu_ready), 1);
        step();
        idle();
        chk_wr("cont.w3", 1, 7, 8'h33);
        rd1_addr = 7;
        #1;
        chk("cont.hz1_w", 32'(hazard1), 1);
        step();
        chk_wr("cont.hold", 0, 7, 8'h33);
        chk("cont.hz1_gone", 32'(hazard1), 0);

        // ALU-only write to 3.
        alu_valid = 1; alu_addr = 3; alu_data = 8'h2A; rd1_addr = 3;
        #1;
        chk("alu.rdy", 32'(alu_ready), 1);
        chk("alu.hz1_pre", 32'(hazard1), 0);
        step();
        idle();
        chk_wr("alu.w", 1, 3, 8'h2A);
        chk("alu.hz1", 32'(hazard1), 1);
        step();
        chk("alu.hz1_after", 32'(hazard1), 0);
        chk("alu.wr_off", 32'(rf_write), 0);

        // Stray return with nothing outstanding is refused.
        mem_valid = 1; mem_data = 8'hEE;
        #1;
        chk("stray.mem_rdy", 32'(mem_ready), 0);
        mem_valid = 0;

        // Load round-trip to 5, data returns three cycles after issue.
        ld_issue = 1; ld_issue_addr = 5; rd2_addr = 5;
        #1;
        chk("ld.hz2_pre", 32'(hazard2), 0);
        for (int i = 0; i < 3; i++) begin
            step();
            ld_issue = 0;
            chk($sformatf("ld.busy%0d", i), 32'(ld_busy), 1);
            chk($sformatf("ld.hz2_%0d", i), 32'(hazard2), 1);
            chk($sformatf("ld.nowr%0d", i), 32'(rf_write), 0);
        end
        mem_valid = 1; mem_data = 8'h77;
        #1;
        chk("ld.mem_rdy", 32'(mem_ready), 1);
        step();
        idle();
        chk_wr("ld.w", 1, 5, 8'h77);
        chk("ld.busy_clr", 32'(ld_busy), 0);
        chk("ld.hz2_wr", 32'(hazard2), 1);
        step();
        chk("ld.hz2_gone", 32'(hazard2), 0);

        // WAW: ALU to 4 held off while a load to 4 is outstanding.
        ld_issue = 1; ld_issue_addr = 4;
        step();
        ld_issue = 0;
        alu_valid = 1; alu_addr = 4; alu_data = 8'h99;
        #1;
        chk("waw.alu_blk0", 32'(alu_ready), 0);
        step();
        chk("waw.alu_blk1", 32'(alu_ready), 0);
        chk("waw.nowr", 32'(rf_write), 0);
        mem_valid = 1; mem_data = 8'hAB;
        #1;
        chk("waw.mem_rdy", 32'(mem_ready), 1);
        chk("waw.alu_blk2", 32'(alu_ready), 0);
        step();
        mem_valid = 0;
        chk_wr("waw.w1", 1, 4, 8'hAB);
        #1;
        chk("waw.alu_rdy", 32'(alu_ready), 1);
        step();
        idle();
        chk_wr("waw.w2", 1, 4, 8'h99);

        // Return coinciding with a new issue to 6; a later issue while busy is ignored.
        ld_issue = 1; ld_issue_addr = 1;
        step();
        ld_issue = 1; ld_issue_addr = 6;
        mem_valid = 1; mem_data = 8'h5C;
        #1;
        chk("rwi.mem_rdy", 32'(mem_ready), 1);
        step();
        idle();
        chk("rwi.busy", 32'(ld_busy), 1);
        chk_wr("rwi.w", 1, 1, 8'h5C);
        rd1_addr = 6; rd2_addr = 1;
        #1;
        chk("rwi.hz1_ld6", 32'(hazard1), 1);
        chk("rwi.hz2_wr1", 32'(hazard2), 1);
        ld_issue = 1; ld_issue_addr = 3;
        step();
        ld_issue = 0;
        rd2_addr = 3;
        #1;
        chk("ign.hz1_ld6", 32'(hazard1), 1);
        chk("ign.hz2_3", 32'(hazard2), 0);

        // Async reset between edges with a write pending and the load busy.
        alu_valid = 1; alu_addr = 2; alu_data = 8'h44;
        step();
        idle();
        chk_wr("ar.pre", 1, 2, 8'h44);
        #2 RESET = 0;
        #1;
        chk_wr("ar.now", 0, 0, 0);
        chk("ar.busy", 32'(ld_busy), 0);
        chk("ar.hz1", 32'(hazard1), 0);
        #2 RESET = 1;
        mem_valid = 1; mem_data = 8'h66;
        #1;
        chk("ar.late_rdy", 32'(mem_ready), 0);
        step();
        chk_wr("ar.post", 0, 0, 0);
        mem_valid = 0;

        // Round-robin state was reset too: the ALU wins the first tie again.
        ld_issue = 1; ld_issue_addr = 5;
        step();
        ld_issue = 0;
        alu_valid = 1; alu_addr = 0; alu_data = 8'h01;
        mem_valid = 1; mem_data = 8'h02;
        #1;
        chk("ar.tie_alu", 32'(alu_ready), 1);
        chk("ar.tie_mem", 32'(mem_ready), 0);
        step();
        idle();
        chk_wr("ar.tie_w", 1, 0, 8'h01);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
